countdown_timer: RTL and testbench



---
 rtl/timer_pkg.sv | 21 ++
 rtl/tick_gen.sv | 32 +++
 rtl/countdown_timer.sv | 118 +++++++++++
 tb/tb_countdown_timer.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
// Shared types and elaboration-time helpers for the countdown timer.
package timer_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RUN     = 2'd1,
      PAUSE   = 2'd2,
      EXPIRED = 2'd3
   } state_t;

   // Clock cycles per countdown tick.
   function automatic int calc_div(input int clk_freq, input int tick_hz);
      return clk_freq / tick_hz;
   endfunction

   // Prescaler counter width; DIV is at least 2, so this is at least 1.
   function automatic int calc_cnt_w(input int div);
      return $clog2(div);
   endfunction

endpackage

// File: rtl/tick_gen.sv
// Prescaler producing one tick every DIV enabled cycles; holds phase when disabled.
module tick_gen
   import timer_pkg::*;
#(
   parameter int CLK_FREQ = 50_000_000,
   parameter int TICK_HZ  = 1
) (
   input  logic clk50M,
   input  logic rst,
   input  logic en,
   input  logic clr,
   output logic tick
);

   localparam int DIV = calc_div(CLK_FREQ, TICK_HZ);
   localparam int CW  = calc_cnt_w(DIV);
   localparam logic [CW-1:0] LAST = CW'(DIV - 1);

   logic [CW-1:0] cnt;

   assign tick = en && (cnt == LAST);

   // Count 0..DIV-1 while enabled, wrap on the tick cycle, clear on request.
   always_ff @(posedge clk50M) begin
      if (rst || clr) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= (cnt == LAST) ? '0 : cnt + CW'(1);
      end
   end

endmodule

// File: rtl/countdown_timer.sv
// Game countdown timer: reload, pause/resume, saturating bonus, warning and timeout.
//
// state   | meaning
// IDLE    | loaded value held, waiting for start
// RUN     | counting down one step per tick
// PAUSE   | countdown frozen, prescaler phase kept
// EXPIRED | reached zero; only load or rst leaves
module countdown_timer
   import timer_pkg::*;
#(
   parameter int CLK_FREQ    = 50_000_000,
   parameter int TICK_HZ     = 1,
   parameter int WIDTH       = 6,
   parameter int INIT_VAL    = 60,
   parameter int MAX_VAL     = 2**WIDTH - 1,
   parameter int WARN_THRESH = 10
) (
   input  logic             clk50M,
   input  logic             rst,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             start,
   input  logic             pause,
   input  logic             bonus_en,
   input  logic [WIDTH-1:0] bonus_val,
   output logic [WIDTH-1:0] time_remain,
   output logic             running,
   output logic             sec_tick,
   output logic             warn,
   output logic             expired,
   output logic             timeout
);

   localparam int WP1 = WIDTH + 1;
   localparam logic [WIDTH:0]   MAX_EXT  = WP1'(MAX_VAL);
   localparam logic [WIDTH-1:0] MAX_W    = WIDTH'(MAX_VAL);
   localparam logic [WIDTH:0]   WARN_EXT = WP1'(WARN_THRESH);

   state_t           state;
   logic             tick;
   logic [WIDTH:0]   sum;
   logic [WIDTH-1:0] nxt;
   logic [WIDTH-1:0] load_clamped;
   logic             enter_exp;

   // Net next value from tick and bonus, one extra bit so saturation sees overflow.
   always_comb begin
      sum = {1'b0, time_remain} - {{WIDTH{1'b0}}, tick};
      if (bonus_en) begin
         sum = sum + {1'b0, bonus_val};
      end
      nxt = (sum > MAX_EXT) ? MAX_W : sum[WIDTH-1:0];
   end

   assign load_clamped = ({1'b0, load_val} > MAX_EXT) ? MAX_W : load_val;
   assign enter_exp    = (state == RUN) && (nxt == '0);

   tick_gen #(
      .CLK_FREQ (CLK_FREQ),
      .TICK_HZ  (TICK_HZ)
   ) u_tick_gen (
      .clk50M (clk50M),
      .rst    (rst),
      .en     (state == RUN),
      .clr    (load || enter_exp),
      .tick   (tick)
   );

   // State, remaining time and the two one-cycle pulses.
   always_ff @(posedge clk50M) begin
      if (rst) begin
         state       <= IDLE;
         time_remain <= WIDTH'(INIT_VAL);
         sec_tick    <= 1'b0;
         timeout     <= 1'b0;
      end else begin
         sec_tick <= 1'b0;
         timeout  <= 1'b0;
         if (load) begin
            state       <= IDLE;
            time_remain <= load_clamped;
         end else begin
            case (state)
               IDLE: begin
                  time_remain <= nxt;
                  if (start && (time_remain != '0)) begin
                     state <= RUN;
                  end
               end
               RUN: begin
                  time_remain <= nxt;
                  sec_tick    <= tick;
                  if (nxt == '0) begin
                     state   <= EXPIRED;
                     timeout <= 1'b1;
                  end else if (pause) begin
                     state <= PAUSE;
                  end
               end
               PAUSE: begin
                  time_remain <= nxt;
                  if (start && !pause) begin
                     state <= RUN;
                  end
               end
               default: begin
                  time_remain <= '0;
               end
            endcase
         end
      end
   end

   assign running = (state == RUN);
   assign expired = (state == EXPIRED);
   assign warn    = ({1'b0, time_remain} <= WARN_EXT) && (time_remain != '0) && (state != EXPIRED);

endmodule

// File: tb/tb_countdown_timer.sv
// Directed plus randomized bench for countdown_timer with a cycle-level reference model.
module tb_countdown_timer;

   localparam int W    = 6;
   localparam int DIV  = 10;
   localparam int INIT = 5;
   localparam int MAXV = 63;
   localparam int WTH  = 2;

   logic         clk50M = 1'b0;
   logic         rst, load, start, pause, bonus_en;
   logic [W-1:0] load_val, bonus_val;
   logic [W-1:0] time_remain;
   logic         running, sec_tick, warn, expired, timeout;

   int n_vec  = 0;
   int n_fail = 0;

   // reference model: remaining time, mode flags, cycles spent counting modulo DIV
   int m_time  = 0;
   int m_phase = 0;
   bit m_run   = 1'b0;
   bit m_pause = 1'b0;
   bit m_exp   = 1'b0;
   bit m_sec   = 1'b0;
   bit m_to    = 1'b0;

   always #5 clk50M = ~clk50M;

   countdown_timer #(
      .CLK_FREQ    (10),
      .TICK_HZ     (1),
      .WIDTH       (W),
      .INIT_VAL    (INIT),
      .MAX_VAL     (MAXV),
      .WARN_THRESH (WTH)
   ) dut (
      .clk50M      (clk50M),
      .rst         (rst),
      .load        (load),
      .load_val    (load_val),
      .start       (start),
      .pause       (pause),
      .bonus_en    (bonus_en),
      .bonus_val   (bonus_val),
      .time_remain (time_remain),
      .running     (running),
      .sec_tick    (sec_tick),
      .warn        (warn),
      .expired     (expired),
      .timeout     (timeout)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance the model by one clock using the inputs currently applied.
   task model_next();
      bit t_tick;
      int t;
      if (rst) begin
         m_time = INIT; m_run = 0; m_pause = 0; m_exp = 0; m_phase = 0; m_sec = 0; m_to = 0;
      end else if (load) begin
         m_time = (int'(load_val) > MAXV) ? MAXV : int'(load_val);
         m_run = 0; m_pause = 0; m_exp = 0; m_phase = 0; m_sec = 0; m_to = 0;
      end else begin
         t_tick = m_run && (m_phase == DIV - 1);
         m_sec  = t_tick;
         m_to   = 0;
         if (m_exp) begin
            m_time = 0;
         end else begin
            t = m_time - (t_tick ? 1 : 0) + (bonus_en ? int'(bonus_val) : 0);
            if (t > MAXV) t = MAXV;
            if (m_run) begin
               m_phase = (m_phase + 1) % DIV;
               if (t == 0) begin
                  m_run = 0; m_exp = 1; m_to = 1; m_phase = 0;
               end else if (pause) begin
                  m_run = 0; m_pause = 1;
               end
            end else if (m_pause) begin
               if (start && !pause) begin
                  m_pause = 0; m_run = 1;
               end
            end else if (start && m_time != 0) begin
               m_run = 1;
            end
            m_time = t;
         end
      end
   endtask

   // One clock: update model, let the edge pass, compare every output.
   task step();
      logic [10:0] e;
      bit          m_warn;
      model_next();
      @(posedge clk50M);
      #1;
      m_warn = (m_time <= WTH) && (m_time != 0) && !m_exp;
      e = {6'(m_time), m_run, m_sec, m_warn, m_exp, m_to};
      check("cycle{time,run,tick,warn,exp,to}",
            32'({time_remain, running, sec_tick, warn, expired, timeout}), 32'(e));
   endtask

   initial begin
      int k;
      int to_cnt;
      bit found;

      rst = 1; load = 0; load_val = '0; start = 0; pause = 0; bonus_en = 0; bonus_val = '0;
      step();
      step();
      rst = 0;
      check("reset_time", 32'(time_remain), INIT);
      check("reset_flags", 32'({running, sec_tick, expired, timeout}), 0);

      // full countdown from INIT_VAL to expiry
      start = 1;
      found = 0; k = 0; to_cnt = 0;
      while (!found && k < 80) begin
         step();
         k++;
         if (timeout) to_cnt++;
         if (time_remain == 6'd2) check("warn_at_2", 32'(warn), 1);
         if (time_remain == 6'd3) check("warn_at_3", 32'(warn), 0);
         if (expired) found = 1;
      end
      check("expiry_cycle", k, 1 + INIT * DIV);
      for (int i = 0; i < 12; i++) begin
         step();
         if (timeout) to_cnt++;
      end
      check("timeout_once", to_cnt, 1);
      check("held_zero", 32'(time_remain), 0);

      // load from EXPIRED, then saturating bonus
      start = 0; load = 1; load_val = 6'd63;
      step();
      load = 0;
      check("load_time", 32'(time_remain), 63);
      check("load_exp_warn", 32'({expired, warn, running}), 0);
      bonus_en = 1; bonus_val = 6'd10;
      step();
      bonus_en = 0;
      check("bonus_sat", 32'(time_remain), 63);

      // pause / resume keeps prescaler phase
      load = 1; load_val = 6'd5;
      step();
      load = 0; start = 1;
      for (int i = 0; i < 25; i++) step();
      check("run25_time", 32'(time_remain), 3);
      pause = 1; start = 0;
      for (int i = 0; i < 40; i++) step();
      check("pause_frozen", 32'(time_remain), 3);
      check("pause_not_running", 32'(running), 0);
      pause = 0; start = 1;
      step();
      check("resume_running", 32'(running), 1);
      k = 0;
      while (time_remain == 6'd3 && k < 20) begin
         step();
         k++;
      end
      check("resume_to_tick", k, 5);

      // bonus coinciding with the final tick
      k = 0;
      while (!(m_time == 1 && m_run && m_phase == DIV - 1) && k < 60) begin
         step();
         k++;
      end
      check("reach_last_sec", 32'(time_remain), 1);
      bonus_en = 1; bonus_val = 6'd4;
      step();
      bonus_en = 0;
      check("bonus_tick_time", 32'(time_remain), 4);
      check("bonus_tick_flags", 32'({running, sec_tick, timeout, expired}), 32'(4'b1100));

      // reset mid-count
      k = 0;
      while (time_remain != 6'd2 && k < 40) begin
         step();
         k++;
      end
      check("reach_2", 32'(time_remain), 2);
      step(); step(); step();
      rst = 1;
      step();
      rst = 0;
      check("midrst_time", 32'(time_remain), INIT);
      check("midrst_flags", 32'({running, sec_tick, timeout, expired}), 0);
      step();
      check("restart_running", 32'(running), 1);
      k = 0;
      while (!sec_tick && k < 20) begin
         step();
         k++;
      end
      check("restart_first_tick", k, DIV);

      // start with zero loaded is ignored
      start = 0; load = 1; load_val = '0;
      step();
      load = 0; start = 1;
      for (int i = 0; i < 5; i++) step();
      check("zero_start_idle", 32'({running, timeout, expired}), 0);
      check("zero_start_time", 32'(time_remain), 0);

      // randomized traffic
      start = 0;
      for (int i = 0; i < 3000; i++) begin
         rst       = ($urandom_range(299) == 0);
         load      = ($urandom_range(39) == 0);
         load_val  = 6'($urandom_range(63));
         bonus_en  = ($urandom_range(14) == 0);
         bonus_val = 6'($urandom_range(63));
         if ($urandom_range(19) == 0) pause = ~pause;
         start     = ($urandom_range(2) == 0);
         step();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
